// File: rtl/crank_stim_pkg.sv
// Shared types and constant helpers for the crank/cam wheel stimulus generator.
package crank_stim_pkg;

  typedef logic [7:0] tooth_t;

  // Ramp arithmetic width: room for the widest prescaler plus sign and one guard bit.
  localparam int unsigned PrescWMax = 32;
  localparam int unsigned CalcW     = PrescWMax + 2;

  // Last sub-tick index of the long (gap) tooth.
  function automatic int unsigned gap_top(input int unsigned sub, input int unsigned missing);
    return (missing + 1) * sub - 1;
  endfunction

  // a - b, clamped to [lo, hi]; hi wins if the bounds cross.
  function automatic logic signed [CalcW-1:0] sat_sub(input logic signed [CalcW-1:0] a,
                                                      input logic signed [CalcW-1:0] b,
                                                      input logic signed [CalcW-1:0] lo,
                                                      input logic signed [CalcW-1:0] hi);
    logic signed [CalcW-1:0] d;
    d = a - b;
    if (d < lo) d = lo;
    if (d > hi) d = hi;
    return d;
  endfunction

endpackage

// File: rtl/tooth_timer.sv
// Prescaler plus sub-tick counter for one tooth pitch; stretches to the gap length on demand.
module tooth_timer
  import crank_stim_pkg::*;
#(
  parameter int unsigned SUB     = 64,
  parameter int unsigned MISSING = 2,
  parameter int unsigned PRESC_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clear,
  input  logic [PRESC_W-1:0] presc,
  input  logic               long_tooth,
  output logic               subtick,
  output logic               tooth_start,
  output logic               tooth_half
);

  localparam int unsigned     GapTop  = gap_top(SUB, MISSING);
  localparam int unsigned     TckcW   = $clog2(GapTop + 1);
  localparam logic [TckcW-1:0] NormTop = TckcW'(SUB - 1);
  localparam logic [TckcW-1:0] LongTop = TckcW'(GapTop);

  logic [PRESC_W-1:0] scnt_q;
  logic [TckcW-1:0]   tckc_q;
  logic [TckcW-1:0]   tckc_top;

  always_comb begin
    tckc_top    = long_tooth ? LongTop : NormTop;
    subtick     = en && (scnt_q == presc);
    tooth_start = subtick && (tckc_q == tckc_top);
    tooth_half  = subtick && (tckc_q == (tckc_top >> 1));
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      scnt_q <= '0;
      tckc_q <= '0;
    end else if (en) begin
      if (subtick) begin
        scnt_q <= '0;
        tckc_q <= tooth_start ? '0 : tckc_q + 1'b1;
      end else begin
        scnt_q <= scnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/crank_cam_stim_gen.sv
// 60-2 style crank wheel and phase-synced cam generator with a per-revolution speed ramp.
module crank_cam_stim_gen
  import crank_stim_pkg::*;
#(
  parameter int unsigned TEETH     = 60,
  parameter int unsigned MISSING   = 2,
  parameter int unsigned SUB       = 64,
  parameter int unsigned PRESC_W   = 16,
  parameter int unsigned PRESC_RST = 31
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               load,
  input  logic [PRESC_W-1:0] presc_init,
  input  logic [PRESC_W-1:0] presc_min,
  input  logic [PRESC_W-1:0] presc_max,
  input  logic [PRESC_W-1:0] accel,
  input  logic [7:0]         cam_fall,
  input  logic [7:0]         cam_rise,
  output logic               vr,
  output logic               cam,
  output logic [7:0]         tooth_idx,
  output logic               rev_strobe,
  output logic               cam_phase,
  output logic [PRESC_W-1:0] presc_cur
);

  localparam tooth_t      LastTooth = tooth_t'(TEETH - MISSING - 1);
  localparam int unsigned ExtW      = CalcW - PRESC_W;

  logic [PRESC_W-1:0] presc_q;
  logic [PRESC_W-1:0] presc_ramp;
  tooth_t             tooth_q;
  tooth_t             tooth_next;
  tooth_t             cam_fall_q;
  tooth_t             cam_rise_q;
  logic               vr_q;
  logic               cam_q;
  logic               cam_d;
  logic               rev_strobe_q;
  logic               cam_phase_q;
  logic               last_tooth;
  logic               subtick;
  logic               tooth_start;
  logic               tooth_half;

  tooth_timer #(
    .SUB     (SUB),
    .MISSING (MISSING),
    .PRESC_W (PRESC_W)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .clear       (load),
    .presc       (presc_q),
    .long_tooth  (last_tooth),
    .subtick     (subtick),
    .tooth_start (tooth_start),
    .tooth_half  (tooth_half)
  );

  always_comb begin
    last_tooth = (tooth_q == LastTooth);
    tooth_next = last_tooth ? '0 : tooth_q + 8'd1;
    // accel is signed; the wide signed subtract keeps the clamp free of wrap-around.
    presc_ramp = PRESC_W'(sat_sub($signed({{ExtW{1'b0}}, presc_q}),
                                  $signed({{ExtW{accel[PRESC_W-1]}}, accel}),
                                  $signed({{ExtW{1'b0}}, presc_min}),
                                  $signed({{ExtW{1'b0}}, presc_max})));
    cam_d = cam_q;
    if (cam_phase_q) begin
      if (tooth_next == cam_rise_q) begin
        cam_d = 1'b1;
      end else if (tooth_next == cam_fall_q) begin
        cam_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q      <= PRESC_W'(PRESC_RST);
      tooth_q      <= '0;
      cam_fall_q   <= '0;
      cam_rise_q   <= '0;
      vr_q         <= 1'b0;
      cam_q        <= 1'b1;
      rev_strobe_q <= 1'b0;
      cam_phase_q  <= 1'b0;
    end else begin
      rev_strobe_q <= 1'b0;
      if (load) begin
        presc_q <= presc_init;
        tooth_q <= '0;
        vr_q    <= 1'b0;
      end else if (subtick) begin
        if (tooth_start) begin
          vr_q    <= 1'b0;
          tooth_q <= tooth_next;
          cam_q   <= cam_d;
          // Revolution boundary: ramp speed and latch the next revolution's cam window.
          if (last_tooth) begin
            rev_strobe_q <= 1'b1;
            cam_phase_q  <= ~cam_phase_q;
            presc_q      <= presc_ramp;
            cam_fall_q   <= cam_fall;
            cam_rise_q   <= cam_rise;
          end
        end else if (tooth_half) begin
          vr_q <= 1'b1;
        end
      end
    end
  end

  assign vr         = vr_q;
  assign cam        = cam_q;
  assign tooth_idx  = tooth_q;
  assign rev_strobe = rev_strobe_q;
  assign cam_phase  = cam_phase_q;
  assign presc_cur  = presc_q;

endmodule
